// File: rtl/i2c_arb_pkg.sv
// Shared encodings for the I2C transaction arbiter: FSM state codes and response-flag bit positions.
package i2c_arb_pkg;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_GRANT_ENC     = 3'd1;
  localparam logic [2:0] ST_START_ENC     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY_ENC = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE_ENC = 3'd4;
  localparam logic [2:0] ST_RESP_ENC      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_GRANT     = ST_GRANT_ENC,
    ST_START     = ST_START_ENC,
    ST_WAIT_BUSY = ST_WAIT_BUSY_ENC,
    ST_WAIT_DONE = ST_WAIT_DONE_ENC,
    ST_RESP      = ST_RESP_ENC
  } arb_state_e;

  localparam int RSP_ACK_ERR_BIT = 0;
  localparam int RSP_TIMEOUT_BIT = 1;
  localparam int RSP_FLAG_W      = 2;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping modulo N.
// Zero latency; found_o is low when no request is pending.
module i2c_rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  logic [PW-1:0] cand;

  // Scan from the farthest offset down so the nearest pending request wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C core among N_REQ clients; ready 2 cycles after request, start 1 later.
// Clients hold req_valid until req_ready; NACKs retried up to RETRY_MAX; I2C_ARB_TIMEOUT_EN adds a wait-phase watchdog.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int RETRY_MAX      = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_read,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_ack_error,
  output logic               rsp_timeout,
  output logic               i2c_start,
  output logic               i2c_read,
  output logic [6:0]         i2c_addr,
  output logic [7:0]         i2c_data_in,
  input  logic [7:0]         i2c_data_out,
  input  logic               i2c_done,
  input  logic               i2c_busy,
  input  logic               i2c_ack_error
);

  localparam int PW = $clog2(N_REQ);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d, idx_q, idx_d;
  logic [RW-1:0]         cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic [6:0]            addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            cap_rdata_q, cap_rdata_d;
  logic                  cap_ack_q, cap_ack_d;
  logic                  cap_tmo_q, cap_tmo_d;
  logic [N_REQ-1:0]      req_ready_q, req_ready_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                  start_q, start_d;
  logic [7:0]            rsp_rdata_q, rsp_rdata_d;
  logic [RSP_FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic          tmo_hit;

  i2c_rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_wait;

  assign in_wait = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign tmo_hit = in_wait && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_START) begin
      tmo_d = '0;
    end else if (in_wait) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  // Watchdog compiled out: the comparison is constant false for any legal timeout.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_rdata_d = cap_rdata_q;
    cap_ack_d   = cap_ack_q;
    cap_tmo_d   = cap_tmo_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    start_d     = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_flags_d = rsp_flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid && !i2c_busy) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        // The requester may have withdrawn since IDLE; fall back without granting.
        if (pick_found) begin
          idx_d                 = pick_idx;
          rd_d                  = req_read[pick_idx];
          addr_d                = req_addr[7*pick_idx +: 7];
          wdata_d               = req_wdata[8*pick_idx +: 8];
          req_ready_d[pick_idx] = 1'b1;
          ptr_d                 = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          cnt_d                 = '0;
          state_d               = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!i2c_busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        if (i2c_done) begin
          cap_rdata_d = rd_q ? i2c_data_out : 8'h00;
          cap_ack_d   = i2c_ack_error;
          cap_tmo_d   = 1'b0;
          if (i2c_ack_error && (cnt_q < RETRY_LIM)) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_RESP;
          end
        end else if (tmo_hit) begin
          cap_rdata_d = 8'h00;
          cap_ack_d   = 1'b0;
          cap_tmo_d   = 1'b1;
          state_d     = ST_RESP;
        end else if ((state_q == ST_WAIT_BUSY) && i2c_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_RESP: begin
        rsp_valid_d[idx_q]           = 1'b1;
        rsp_rdata_d                  = cap_rdata_q;
        rsp_flags_d                  = '0;
        rsp_flags_d[RSP_ACK_ERR_BIT] = cap_ack_q;
        rsp_flags_d[RSP_TIMEOUT_BIT] = cap_tmo_q;
        state_d                      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_rdata_q <= '0;
      cap_ack_q   <= 1'b0;
      cap_tmo_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_rdata_q <= cap_rdata_d;
      cap_ack_q   <= cap_ack_d;
      cap_tmo_q   <= cap_tmo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_ack_error = rsp_flags_q[RSP_ACK_ERR_BIT];
  assign rsp_timeout   = rsp_flags_q[RSP_TIMEOUT_BIT];
  assign i2c_start     = start_q;
  assign i2c_read      = rd_q;
  assign i2c_addr      = addr_q;
  assign i2c_data_in   = wdata_q;

endmodule
